// File: rtl/phy_rx_lanes_if.sv
// Lane-receiver bus: serial input plus parallel lane outputs.
// Ports: data_in (serial), active, valid, data_out, valid_out, lane_ptr.
interface phy_rx_lanes_if #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_LANES  = 4
);
  localparam int LPW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

  logic                            data_in;
  logic                            active;
  logic                            valid;
  logic [NUM_LANES*DATA_WIDTH-1:0] data_out;
  logic [NUM_LANES-1:0]            valid_out;
  logic [LPW-1:0]                  lane_ptr;

  modport master (
    output data_in,
    input  active, valid, data_out, valid_out, lane_ptr
  );

  modport slave (
    input  data_in,
    output active, valid, data_out, valid_out, lane_ptr
  );
endinterface

// File: rtl/phy_rx_lanes.sv
// Serial PHY receiver: comma bit-slide alignment, lane distribution.
// Ports: clk_32f, default_values (sync reset), bus (slave side).
module phy_rx_lanes #(
  parameter int                    DATA_WIDTH = 8,
  parameter int                    NUM_LANES  = 4,
  parameter logic [DATA_WIDTH-1:0] SYNC_WORD  = 8'hBC,
  parameter int                    SYNC_COUNT = 4
) (
  input  logic          clk_32f,
  input  logic          default_values,
  phy_rx_lanes_if.slave bus
);
  localparam int LPW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
  localparam int BCW = $clog2(DATA_WIDTH);
  localparam int SCW = $clog2(SYNC_COUNT + 1);
  localparam int DW  = NUM_LANES * DATA_WIDTH;

  localparam logic [BCW-1:0] BC_LAST = BCW'(DATA_WIDTH - 1);
  localparam logic [SCW-1:0] SC_DONE = SCW'(SYNC_COUNT);
  localparam logic [LPW-1:0] LP_LAST = LPW'(NUM_LANES - 1);

  typedef enum logic [1:0] {
    S_SEARCH,
    S_ALIGN,
    S_ACTIVE
  } state_t;

  state_t                r_state;
  state_t                w_state;
  logic [DATA_WIDTH-2:0] r_sr;
  logic [DATA_WIDTH-2:0] w_sr;
  logic [BCW-1:0]        r_bit_cnt;
  logic [BCW-1:0]        w_bit_cnt;
  logic [SCW-1:0]        r_sync_cnt;
  logic [SCW-1:0]        w_sync_cnt;
  logic [DW-1:0]         r_data;
  logic [DW-1:0]         w_data;
  logic [NUM_LANES-1:0]  r_vo;
  logic [NUM_LANES-1:0]  w_vo;
  logic [LPW-1:0]        r_lane_ptr;
  logic [LPW-1:0]        w_lane_ptr;
  logic                  r_active;
  logic                  r_valid;

  logic [DATA_WIDTH-1:0] w_cand;
  logic                  w_match;
  logic                  w_wend;

  // Candidate word includes the bit arriving this cycle.
  assign w_cand  = {r_sr, bus.data_in};
  assign w_match = (w_cand == SYNC_WORD);
  assign w_wend  = (r_bit_cnt == BC_LAST);

  always_ff @(posedge clk_32f) begin
    if (default_values) r_state <= S_SEARCH;
    else                r_state <= w_state;
  end

  always_comb begin
    w_state    = r_state;
    w_sr       = w_cand[DATA_WIDTH-2:0];
    w_bit_cnt  = r_bit_cnt;
    w_sync_cnt = r_sync_cnt;
    w_data     = r_data;
    w_vo       = '0;
    w_lane_ptr = r_lane_ptr;
    if (r_state != S_SEARCH)
      w_bit_cnt = w_wend ? '0 : r_bit_cnt + 1'b1;
    unique case (r_state)
      S_SEARCH: begin
        if (w_match) begin
          w_bit_cnt  = '0;
          w_sync_cnt = SCW'(1);
          w_state    = (SYNC_COUNT == 1) ? S_ACTIVE : S_ALIGN;
        end
      end
      S_ALIGN: begin
        if (w_wend) begin
          if (w_match) begin
            w_sync_cnt = r_sync_cnt + 1'b1;
            if (w_sync_cnt == SC_DONE) begin
              w_state    = S_ACTIVE;
              w_lane_ptr = '0;
            end
          end else begin
            w_state    = S_SEARCH;
            w_sync_cnt = '0;
          end
        end
      end
      S_ACTIVE: begin
        if (w_wend) begin
          if (w_match) begin
            // Idle comma realigns the lane pointer.
            w_lane_ptr = '0;
          end else begin
            for (int i = 0; i < NUM_LANES; i++) begin
              if (r_lane_ptr == LPW'(i)) begin
                w_data[i*DATA_WIDTH +: DATA_WIDTH] = w_cand;
                w_vo[i] = 1'b1;
              end
            end
            w_lane_ptr = (r_lane_ptr == LP_LAST) ? '0
                       : r_lane_ptr + 1'b1;
          end
        end
      end
      default: w_state = S_SEARCH;
    endcase
  end

  always_ff @(posedge clk_32f) begin
    if (default_values) begin
      r_sr       <= '0;
      r_bit_cnt  <= '0;
      r_sync_cnt <= '0;
      r_data     <= '0;
      r_vo       <= '0;
      r_lane_ptr <= '0;
      r_active   <= 1'b0;
      r_valid    <= 1'b0;
    end else begin
      r_sr       <= w_sr;
      r_bit_cnt  <= w_bit_cnt;
      r_sync_cnt <= w_sync_cnt;
      r_data     <= w_data;
      r_vo       <= w_vo;
      r_lane_ptr <= w_lane_ptr;
      r_active   <= (w_state == S_ACTIVE);
      r_valid    <= |w_vo;
    end
  end

  assign bus.active    = r_active;
  assign bus.valid     = r_valid;
  assign bus.data_out  = r_data;
  assign bus.valid_out = r_vo;
  assign bus.lane_ptr  = r_lane_ptr;
endmodule

// File: tb/tb_phy_rx_lanes.sv
// Testbench for phy_rx_lanes: directed plan plus random words.
// Behavioural model compared against the DUT every cycle.
module tb_phy_rx_lanes;
  localparam int              DW   = 8;
  localparam int              NL   = 4;
  localparam logic [DW-1:0]   SYNC = 8'hBC;
  localparam int              SC   = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  phy_rx_lanes_if #(.DATA_WIDTH(DW), .NUM_LANES(NL)) bus ();

  phy_rx_lanes #(
    .DATA_WIDTH(DW), .NUM_LANES(NL),
    .SYNC_WORD(SYNC), .SYNC_COUNT(SC)
  ) dut (
    .clk_32f(clk),
    .default_values(rst),
    .bus(bus.slave)
  );

  int vectors = 0;
  int errors  = 0;
  bit chk_en  = 1'b0;

  // Model: bit history, mode (0 search, 1 align, 2 active),
  // bits received since alignment, comma run, lane contents.
  logic [DW-2:0] m_hist;
  int            m_mode;
  int            m_nbits;
  int            m_commas;
  int            m_ptr;
  logic [DW-1:0] m_lane [NL];
  logic [NL-1:0] m_vo;
  logic          m_active;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h",
               name, $time, act, exp);
    end
  endtask

  task automatic model(input logic r, input logic d);
    logic [DW-1:0] w;
    m_vo = '0;
    if (r) begin
      m_hist = '0; m_mode = 0; m_nbits = 0;
      m_commas = 0; m_ptr = 0; m_active = 1'b0;
      for (int i = 0; i < NL; i++) m_lane[i] = '0;
      return;
    end
    w = {m_hist, d};
    m_hist = w[DW-2:0];
    if (m_mode == 0) begin
      if (w == SYNC) begin
        m_nbits = 0;
        m_commas = 1;
        m_mode = (SC == 1) ? 2 : 1;
      end
    end else begin
      m_nbits++;
      if (m_nbits == DW) begin
        m_nbits = 0;
        if (m_mode == 1) begin
          if (w == SYNC) begin
            m_commas++;
            if (m_commas == SC) begin
              m_mode = 2;
              m_ptr = 0;
            end
          end else begin
            m_mode = 0;
            m_commas = 0;
          end
        end else if (w == SYNC) begin
          m_ptr = 0;
        end else begin
          m_lane[m_ptr] = w;
          m_vo[m_ptr] = 1'b1;
          m_ptr = (m_ptr + 1) % NL;
        end
      end
    end
    m_active = (m_mode == 2);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("active", 64'(bus.active), 64'(m_active));
      check("valid", 64'(bus.valid), 64'(|m_vo));
      check("valid_out", 64'(bus.valid_out), 64'(m_vo));
      check("lane_ptr", 64'(bus.lane_ptr), 64'(m_ptr));
      for (int i = 0; i < NL; i++)
        check($sformatf("lane%0d", i),
              64'(bus.data_out[i*DW +: DW]), 64'(m_lane[i]));
    end
  end

  task automatic step(input logic r, input logic d);
    @(negedge clk);
    rst = r;
    bus.data_in = d;
    @(posedge clk);
    model(r, d);
    #1;
  endtask

  task automatic send_word(input logic [DW-1:0] w);
    for (int i = DW - 1; i >= 0; i--) step(1'b0, w[i]);
  endtask

  task automatic send_bits_except_last(input logic [DW-1:0] w);
    for (int i = DW - 1; i >= 1; i--) step(1'b0, w[i]);
  endtask

  initial begin
    bus.data_in = 1'b0;
    // 1: reset held with toggling data.
    for (int i = 0; i < 3; i++) begin
      step(1'b1, i[0]);
      chk_en = 1'b1;
    end
    check("rst_active", 64'(bus.active), 64'd0);
    check("rst_data", 64'(bus.data_out), 64'd0);

    // 2: junk then four commas.
    step(1'b0, 1'b1); step(1'b0, 1'b0); step(1'b0, 1'b1);
    for (int i = 0; i < SC - 1; i++) send_word(SYNC);
    send_bits_except_last(SYNC);
    check("pre_active", 64'(bus.active), 64'd0);
    step(1'b0, SYNC[0]);
    check("t2_active", 64'(bus.active), 64'd1);

    // 3: four data words across the lanes.
    send_word(8'hFF);
    check("t3_vo0", 64'(bus.valid_out), 64'b0001);
    send_word(8'hEE);
    check("t3_vo1", 64'(bus.valid_out), 64'b0010);
    send_word(8'hDD);
    check("t3_vo2", 64'(bus.valid_out), 64'b0100);
    send_word(8'hCC);
    check("t3_vo3", 64'(bus.valid_out), 64'b1000);
    check("t3_lanes", 64'(bus.data_out), 64'hCCDDEEFF);
    check("t3_ptr", 64'(bus.lane_ptr), 64'd0);

    // 4: comma mid-stream realigns to lane 0.
    send_word(8'hBB);
    check("t4_bb", 64'(bus.data_out[DW-1:0]), 64'hBB);
    send_word(SYNC);
    check("t4_idle", 64'(bus.valid_out), 64'd0);
    send_word(8'h11);
    check("t4_11", 64'(bus.data_out[DW-1:0]), 64'h11);
    check("t4_vo", 64'(bus.valid_out), 64'b0001);
    check("t4_ptr", 64'(bus.lane_ptr), 64'd1);

    // 5: broken comma run drops back to search.
    step(1'b1, 1'b0);
    send_word(SYNC); send_word(SYNC); send_word(8'h00);
    check("t5_search", 64'(bus.active), 64'd0);
    for (int i = 0; i < SC; i++) send_word(SYNC);
    check("t5_active", 64'(bus.active), 64'd1);

    // 6: reset mid-word while active.
    send_word(8'h5A);
    step(1'b0, 1'b1); step(1'b0, 1'b0); step(1'b0, 1'b1);
    step(1'b1, 1'b0);
    check("t6_active", 64'(bus.active), 64'd0);
    check("t6_data", 64'(bus.data_out), 64'd0);
    check("t6_ptr", 64'(bus.lane_ptr), 64'd0);
    for (int i = 0; i < SC - 1; i++) send_word(SYNC);
    check("t6_not_yet", 64'(bus.active), 64'd0);
    send_word(SYNC);
    check("t6_resync", 64'(bus.active), 64'd1);

    // Random traffic with commas, junk bits and resets.
    for (int run = 0; run < 3; run++) begin
      step(1'b1, 1'b0);
      for (int i = 0; i < SC; i++) send_word(SYNC);
      for (int k = 0; k < 80; k++) begin
        int sel;
        sel = $urandom_range(0, 99);
        if (sel < 25) send_word(SYNC);
        else if (sel < 85) send_word(DW'($urandom));
        else if (sel < 95) begin
          int n;
          n = $urandom_range(1, DW - 1);
          for (int b = 0; b < n; b++)
            step(1'b0, 1'($urandom_range(0, 1)));
        end else step(1'b1, 1'($urandom_range(0, 1)));
      end
    end

    @(negedge clk);
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, errors);
    $finish;
  end
endmodule
